fir_iq_stream: RTL and testbench
================================

# fir_iq_stream

Parametrised complex (I/Q) streaming FIR filter with a runtime-loadable coefficient bank, full AXI-Stream backpressure, and per-packet zero-flush. It sits between the ADC-side DDC output and the downstream decimator/correlator. It replaces the fixed 15-tap filter with configurable depth, independent real/imag lanes, rounding/saturation, and packet-isolated delay lines.

## Interface
Parameters:
- NUM_TAPS, 15: filter length, 2..64.
- COEFF_WIDTH, 18: signed coefficient width.
- OUT_SHIFT, 16: arithmetic right shift applied before output rounding, ≥1.
- ACC_WIDTH, 16+COEFF_WIDTH+$clog2(NUM_TAPS): accumulator width per lane.

Ports:
- s00_axis_aclk, in, 1: the single clock.
- s00_axis_areset, in, 1: asynchronous active-high reset.
- s00_axis_tvalid / s00_axis_tlast, in, 1: input stream.
- s00_axis_tdata, in, 32: [31:16] real, [15:0] imag, both signed.
- s00_axis_tready, out, 1.
- m00_axis_tready, in, 1.
- m00_axis_tvalid / m00_axis_tlast, out, 1.
- m00_axis_tdata, out, 32: same packing as input.
- m00_axis_tstrb, out, 4: constant 4'hF.
- coeff_wr_en, in, 1: write the shadow bank.
- coeff_wr_addr, in, $clog2(NUM_TAPS): tap index.
- coeff_wr_data, in, COEFF_WIDTH: signed coefficient.
- coeff_commit, in, 1: request a shadow→active copy.
- sat_flag, out, 1: sticky, set on any output saturation. Cleared by reset or coeff_commit acceptance.

## Operation
- Structure: transposed-form FIR, identical for both lanes. Both lanes share the active coefficients. y[n] = Σ c[k]·x[n−k].
- States: RUN, FLUSH.
- RUN: s00_axis_tready = !m00_axis_tvalid || m00_axis_tready. Each accepted beat advances the delay line once and loads the output register.
- Accepting a beat with tlast=1 moves the block to FLUSH.
- FLUSH: s00_axis_tready=0. The block injects NUM_TAPS−1 zero samples, one per cycle in which the output slot is free. The final flush output carries m00_axis_tlast=1. After it, all accumulators clear to 0 and the block returns to RUN.
- Outputs per packet: N input beats yield exactly N+NUM_TAPS−1 outputs (full convolution). Every beat is emitted, with no warm-up suppression.
- Arithmetic per lane: acc = sign-extended product sum in ACC_WIDTH, with no internal overflow. out = (acc + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, then saturated to [−32768, 32767].
- Coefficients: coeff_wr_en writes the shadow bank at any time. coeff_commit is latched as pending. The copy to the active bank happens when the block is in RUN with no packet in progress, i.e. after reset or after a flush and before the next accepted beat.
- A packet never sees a coefficient change mid-packet.
- If a beat is offered in the same cycle as a pending commit with no packet active, the commit applies first and that beat uses the new coefficients.
- Reset: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, sat_flag=0, state=RUN. Accumulators and pending commit clear. Both coefficient banks reset to all-zero.
- Reset mid-packet or mid-flush abandons the packet; no tlast is emitted.

## Timing
- Latency: a beat accepted at edge k produces its output with m00_axis_tvalid=1 after edge k, so it is visible in cycle k+1.
- Throughput: 1 beat/cycle when m00_axis_tready is held high.
- m00_axis_tdata/tlast remain stable while tvalid=1 and tready=0.
- Flush of NUM_TAPS−1 outputs takes NUM_TAPS−1 cycles minimum, extended 1:1 by backpressure.
- The first beat of the next packet can be accepted in the cycle after the tlast output handshakes.

## Structure
- Package fir_iq_pkg holds the lane packing helpers (re/im extract/pack), the state enum typedef, and the saturate/round function.
- One sub-module, fir_lane: a single-lane transposed FIR plus round/saturate. It is instantiated twice and driven by a shared advance enable and the active coefficient array.
- The top level owns the FSM, the handshake, the coefficient banks and the commit logic.

## Test plan
All scenarios use NUM_TAPS=4, OUT_SHIFT=1, coefficients {2,4,6,8} committed after reset.
- Impulse: single beat (1,−1) with tlast → outputs real 1,2,3,4 and imag −1,−2,−3,−4; tlast only on the 4th; tready low for 3 cycles.
- Streaming: 8-beat packet of real=100, imag=0, tready high → 11 outputs. Steady-state real value is 1000, with one output per cycle.
- Backpressure: same packet with m00_axis_tready toggling 1,0,0,1 → identical output sequence. No output changes while stalled; no beats are lost or duplicated.
- Saturation: real=32767 constant across 4 beats → output 32767 and sat_flag=1. Imag=−32768 constant → output −32768.
- Commit deferral: write new coefficients {0,0,0,2} and pulse coeff_commit mid-packet → the rest of the packet uses {2,4,6,8}. Next packet impulse (1,0) → outputs 0,0,0,1.
- Reset mid-flush: assert s00_axis_areset during FLUSH → tvalid=0 immediately. A subsequent impulse yields all-zero outputs, since the banks were reset.

Source files
------------

// File: rtl/fir_iq_pkg.sv
// fir_iq_stream shared types and helpers:
// I/Q lane packing, FSM state and round/saturate.
package fir_iq_pkg;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [15:0] val;
    logic        sat;
  } rs_t;

  function automatic logic [15:0] get_re(input logic [31:0] d);
    return d[31:16];
  endfunction

  function automatic logic [15:0] get_im(input logic [31:0] d);
    return d[15:0];
  endfunction

  function automatic logic [31:0] pack_iq(
    input logic [15:0] re,
    input logic [15:0] im
  );
    return {re, im};
  endfunction

  // Round half-up, arithmetic shift, clamp to int16
  function automatic rs_t round_sat(
    input logic signed [63:0] acc,
    input int                 sh
  );
    logic signed [63:0] r;
    rs_t o;
    r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 64'sd32767) begin
      o.val = 16'h7fff;
      o.sat = 1'b1;
    end else if (r < -64'sd32768) begin
      o.val = 16'h8000;
      o.sat = 1'b1;
    end else begin
      o.val = r[15:0];
      o.sat = 1'b0;
    end
    return o;
  endfunction

endpackage

// File: rtl/fir_iq_stream_lane.sv
// Single-lane transposed-form FIR with a registered
// rounded/saturated output.
module fir_lane
  import fir_iq_pkg::*;
#(
  parameter int NUM_TAPS    = 15,
  parameter int COEFF_WIDTH = 18,
  parameter int OUT_SHIFT   = 16,
  parameter int ACC_WIDTH   = 16 + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  adv,
  input  logic                                  clr,
  input  logic signed [15:0]                    x,
  input  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0]  coeff,
  output logic [15:0]                           y,
  output logic                                  sat_hit
);

  logic signed [ACC_WIDTH-1:0] prod [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] z    [NUM_TAPS-1];
  logic signed [ACC_WIDTH-1:0] acc;
  rs_t                         rs;

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod[k] = ACC_WIDTH'(x) * ACC_WIDTH'($signed(coeff[k]));
    end
    acc     = prod[0] + z[0];
    rs      = round_sat(64'(acc), OUT_SHIFT);
    sat_hit = rs.sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      for (int k = 0; k < NUM_TAPS - 1; k++) begin
        z[k] <= '0;
      end
    end else if (adv) begin
      y <= rs.val;
      for (int k = 0; k < NUM_TAPS - 2; k++) begin
        z[k] <= prod[k+1] + z[k+1];
      end
      z[NUM_TAPS-2] <= prod[NUM_TAPS-1];
      // End of flush: start the next packet from a clean line
      if (clr) begin
        for (int k = 0; k < NUM_TAPS - 1; k++) begin
          z[k] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/fir_iq_stream.sv
// Complex streaming FIR: AXI-Stream handshake, packet flush,
// shadow/active coefficient banks with deferred commit.
module fir_iq_stream
  import fir_iq_pkg::*;
#(
  parameter int NUM_TAPS    = 15,
  parameter int COEFF_WIDTH = 18,
  parameter int OUT_SHIFT   = 16,
  parameter int ACC_WIDTH   = 16 + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                         s00_axis_aclk,
  input  logic                         s00_axis_areset,
  input  logic                         s00_axis_tvalid,
  input  logic                         s00_axis_tlast,
  input  logic [31:0]                  s00_axis_tdata,
  output logic                         s00_axis_tready,
  input  logic                         m00_axis_tready,
  output logic                         m00_axis_tvalid,
  output logic                         m00_axis_tlast,
  output logic [31:0]                  m00_axis_tdata,
  output logic [3:0]                   m00_axis_tstrb,
  input  logic                         coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0]  coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0]       coeff_wr_data,
  input  logic                         coeff_commit,
  output logic                         sat_flag
);

  localparam int AW = $clog2(NUM_TAPS);

  state_t                              state;
  logic                                pkt_act;
  logic                                pend;
  logic [AW-1:0]                       cnt;
  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] shadow;
  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] active;
  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] coeff_use;
  logic                                slot_free;
  logic                                acc_beat;
  logic                                adv;
  logic                                flush_last;
  logic                                commit_now;
  logic                                hit_re;
  logic                                hit_im;
  logic signed [15:0]                  x_re;
  logic signed [15:0]                  x_im;
  logic [15:0]                         y_re;
  logic [15:0]                         y_im;

  assign slot_free  = !m00_axis_tvalid || m00_axis_tready;
  assign s00_axis_tready = (state == ST_RUN) && slot_free;
  assign acc_beat   = s00_axis_tvalid && s00_axis_tready;
  assign adv        = acc_beat || ((state == ST_FLUSH) && slot_free);
  assign flush_last = (state == ST_FLUSH) && (cnt == AW'(NUM_TAPS - 2));
  // Swap only between packets; a same-cycle beat sees the new bank
  assign commit_now = (pend || coeff_commit) && (state == ST_RUN) && !pkt_act;
  assign coeff_use  = commit_now ? shadow : active;
  assign x_re = (state == ST_FLUSH) ? 16'sd0 : get_re(s00_axis_tdata);
  assign x_im = (state == ST_FLUSH) ? 16'sd0 : get_im(s00_axis_tdata);
  assign m00_axis_tdata = pack_iq(y_re, y_im);
  assign m00_axis_tstrb = 4'hF;

  fir_lane #(
    .NUM_TAPS(NUM_TAPS), .COEFF_WIDTH(COEFF_WIDTH),
    .OUT_SHIFT(OUT_SHIFT), .ACC_WIDTH(ACC_WIDTH)
  ) u_re (
    .clk(s00_axis_aclk), .rst(s00_axis_areset),
    .adv(adv), .clr(flush_last), .x(x_re),
    .coeff(coeff_use), .y(y_re), .sat_hit(hit_re)
  );

  fir_lane #(
    .NUM_TAPS(NUM_TAPS), .COEFF_WIDTH(COEFF_WIDTH),
    .OUT_SHIFT(OUT_SHIFT), .ACC_WIDTH(ACC_WIDTH)
  ) u_im (
    .clk(s00_axis_aclk), .rst(s00_axis_areset),
    .adv(adv), .clr(flush_last), .x(x_im),
    .coeff(coeff_use), .y(y_im), .sat_hit(hit_im)
  );

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state           <= ST_RUN;
      pkt_act         <= 1'b0;
      pend            <= 1'b0;
      cnt             <= '0;
      shadow          <= '0;
      active          <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      if (coeff_wr_en && (int'(coeff_wr_addr) < NUM_TAPS)) begin
        shadow[coeff_wr_addr] <= coeff_wr_data;
      end
      if (commit_now) begin
        active <= shadow;
        pend   <= 1'b0;
      end else if (coeff_commit) begin
        pend   <= 1'b1;
      end
      sat_flag <= (sat_flag && !commit_now) || (adv && (hit_re || hit_im));
      if (adv) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= flush_last;
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
      unique case (state)
        ST_RUN: begin
          if (acc_beat) begin
            pkt_act <= !s00_axis_tlast;
            if (s00_axis_tlast) begin
              state <= ST_FLUSH;
              cnt   <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (adv) begin
            cnt <= cnt + 1'b1;
            if (flush_last) begin
              state <= ST_RUN;
              cnt   <= '0;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_iq_stream.sv
// Randomized self-checking bench for fir_iq_stream against a
// direct-convolution reference model and output scoreboard.
module tb_fir_iq_stream;

  localparam int T  = 4;
  localparam int CW = 18;
  localparam int SH = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic          s_tready;
  logic          m_tready = 1'b1;
  logic          m_tvalid;
  logic          m_tlast;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tstrb;
  logic          c_wr_en = 1'b0;
  logic [1:0]    c_wr_addr = '0;
  logic [CW-1:0] c_wr_data = '0;
  logic          c_commit = 1'b0;
  logic          sat_flag;

  always #5 clk = ~clk;

  fir_iq_stream #(
    .NUM_TAPS(T), .COEFF_WIDTH(CW), .OUT_SHIFT(SH)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tready(s_tready),
    .m00_axis_tready(m_tready), .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast), .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb), .coeff_wr_en(c_wr_en),
    .coeff_wr_addr(c_wr_addr), .coeff_wr_data(c_wr_data),
    .coeff_commit(c_commit), .sat_flag(sat_flag)
  );

  typedef struct {
    int re;
    int im;
    bit last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          sh_c[T];
  int          act_c[T];
  int          nc[T];
  bit          pend_m = 1'b0;
  bit          sat_m = 1'b0;
  int          pkt_re[$];
  int          pkt_im[$];
  int          ready_mode = 0;
  int          ready_ph = 0;
  longint      cyc = 0;
  longint      first_cyc = 0;
  longint      last_cyc = 0;
  bit          first_seen = 1'b0;
  int          out_cnt = 0;
  int          low_cnt = 0;
  bit          stall_p = 1'b0;
  logic [31:0] stall_d = '0;
  logic        stall_l = 1'b0;

  task automatic chk(
    input string              tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rsat(input longint acc, output bit s);
    longint r;
    r = (acc + (longint'(1) << (SH - 1))) >>> SH;
    s = 1'b0;
    if (r > 32767) begin
      r = 32767;
      s = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      s = 1'b1;
    end
    return int'(r);
  endfunction

  // Full convolution of the packet with the active bank
  task automatic push_expected();
    int n;
    longint ar, ai;
    bit s1, s2;
    exp_t e;
    n = pkt_re.size();
    for (int j = 0; j < n + T - 1; j++) begin
      ar = 0;
      ai = 0;
      for (int k = 0; k < T; k++) begin
        if (j - k >= 0 && j - k < n) begin
          ar += longint'(act_c[k]) * longint'(pkt_re[j-k]);
          ai += longint'(act_c[k]) * longint'(pkt_im[j-k]);
        end
      end
      e.re   = rsat(ar, s1);
      e.im   = rsat(ai, s2);
      e.last = (j == n + T - 2);
      sat_m  = sat_m | s1 | s2;
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: begin
        m_tready = (ready_ph == 0) || (ready_ph == 3);
        ready_ph = (ready_ph + 1) % 4;
      end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", 64'(m_tvalid), 1);
        chk("stall_data", 64'(m_tdata), 64'(stall_d));
        chk("stall_last", 64'(m_tlast), 64'(stall_l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", 64'(m_tvalid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_re", $signed(m_tdata[31:16]), mon_e.re);
          chk("out_im", $signed(m_tdata[15:0]), mon_e.im);
          chk("out_last", 64'(m_tlast), 64'(mon_e.last));
          out_cnt++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_cyc  = cyc;
          end
          if (m_tlast) last_cyc = cyc;
        end
      end
      stall_p = m_tvalid && !m_tready;
      stall_d = m_tdata;
      stall_l = m_tlast;
    end
  end

  task automatic load_coeffs(input int c[T], input bit idle);
    for (int k = 0; k < T; k++) begin
      c_wr_en   = 1'b1;
      c_wr_addr = 2'(k);
      c_wr_data = CW'(c[k]);
      sh_c[k]   = c[k];
      @(posedge clk);
      #1;
    end
    c_wr_en  = 1'b0;
    c_commit = 1'b1;
    @(posedge clk);
    #1;
    c_commit = 1'b0;
    if (idle) begin
      act_c = sh_c;
      sat_m = 1'b0;
    end else begin
      pend_m = 1'b1;
    end
  endtask

  task automatic wait_accept();
    int t;
    t = 0;
    @(negedge clk);
    while (!s_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("beat_accepted", 64'(s_tready), 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pkt_add(input int re, input int im);
    pkt_re.push_back(re);
    pkt_im.push_back(im);
  endtask

  task automatic send_pkt(input int commit_at, input bit count_low);
    int n;
    n = pkt_re.size();
    push_expected();
    first_seen = 1'b0;
    out_cnt    = 0;
    for (int i = 0; i < n; i++) begin
      if (i == commit_at) load_coeffs(nc, 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = {16'(pkt_re[i]), 16'(pkt_im[i])};
      s_tlast  = (i == n - 1);
      wait_accept();
    end
    low_cnt = 0;
    if (count_low) begin
      @(negedge clk);
      while (!s_tready && low_cnt < 200) begin
        low_cnt++;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 64'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    if (pend_m) begin
      act_c  = sh_c;
      pend_m = 1'b0;
      sat_m  = 1'b0;
    end
    chk("sat_flag", 64'(sat_flag), 64'(sat_m));
    pkt_re.delete();
    pkt_im.delete();
  endtask

  initial begin
    int len, ca;
    for (int k = 0; k < T; k++) begin
      sh_c[k]  = 0;
      act_c[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tvalid", 64'(m_tvalid), 0);
    chk("reset_tlast", 64'(m_tlast), 0);
    chk("reset_tdata", 64'(m_tdata), 0);
    chk("reset_sat", 64'(sat_flag), 0);
    chk("reset_s_tready", 64'(s_tready), 1);
    chk("tstrb", 64'(m_tstrb), 64'hF);
    @(posedge clk);
    #1;

    nc = '{2, 4, 6, 8};
    load_coeffs(nc, 1'b1);

    pkt_add(1, -1);
    send_pkt(-1, 1'b1);
    chk("impulse_tready_low", 64'(low_cnt), T - 1);
    drain();
    chk("impulse_outputs", 64'(out_cnt), T);

    for (int i = 0; i < 8; i++) pkt_add(100, 0);
    send_pkt(-1, 1'b0);
    drain();
    chk("stream_outputs", 64'(out_cnt), 8 + T - 1);
    chk("stream_span", last_cyc - first_cyc, 8 + T - 2);

    ready_mode = 1;
    ready_ph   = 0;
    for (int i = 0; i < 8; i++) pkt_add(100, 0);
    send_pkt(-1, 1'b0);
    drain();
    chk("bp_outputs", 64'(out_cnt), 8 + T - 1);

    ready_mode = 0;
    for (int i = 0; i < 4; i++) pkt_add(32767, -32768);
    send_pkt(-1, 1'b0);
    drain();
    chk("sat_set", 64'(sat_flag), 1);

    nc = '{0, 0, 0, 2};
    for (int i = 0; i < 6; i++) begin
      pkt_add(int'($urandom_range(0, 400)) - 200,
              int'($urandom_range(0, 400)) - 200);
    end
    send_pkt(3, 1'b0);
    drain();
    pkt_add(1, 0);
    send_pkt(-1, 1'b0);
    drain();

    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < T; k++) nc[k] = int'($urandom_range(0, 600)) - 300;
      if (r % 2 == 0) load_coeffs(nc, 1'b1);
      len = int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) begin
        if (r % 3 == 0) begin
          pkt_add(int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
        end else begin
          pkt_add(int'($urandom_range(0, 4000)) - 2000,
                  int'($urandom_range(0, 4000)) - 2000);
        end
      end
      ca = (r % 2 == 1 && len >= 2) ? int'($urandom_range(1, len - 1)) : -1;
      send_pkt(ca, 1'b0);
      drain();
    end

    ready_mode = 0;
    nc = '{1, 1, 1, 1};
    load_coeffs(nc, 1'b1);
    for (int i = 0; i < 3; i++) pkt_add(50, 50);
    send_pkt(-1, 1'b0);
    chk("flush_tvalid", 64'(m_tvalid), 1);
    chk("flush_s_tready", 64'(s_tready), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_flush_tvalid", 64'(m_tvalid), 0);
    chk("rst_flush_tlast", 64'(m_tlast), 0);
    exp_q.delete();
    pkt_re.delete();
    pkt_im.delete();
    for (int k = 0; k < T; k++) begin
      sh_c[k]  = 0;
      act_c[k] = 0;
    end
    pend_m = 1'b0;
    sat_m  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pkt_add(1, 0);
    send_pkt(-1, 1'b0);
    drain();
    chk("post_rst_outputs", 64'(out_cnt), T);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
